mmm_nlp_mul_arb: RTL and testbench
==================================

# mmm_nlp_mul_arb

Round-robin arbiter and issue sequencer sharing one pipelined 90-bit multiplier (`mmm_nlp_90b`, computes a*b+carry) between NREQ requesters. It accepts operand requests over valid/ready handshakes and issues at most one per cycle to the multiplier. A tag pipeline tracks requests through the fixed multiplier latency. Results are buffered in a credit-protected response FIFO with backpressure, returned in issue order and tagged with the requester id. It sits between the Montgomery-step controllers and the multiplier instance.

## Interface
- IDW, 90, operand width
- ODW, 181, result width (must be ≥ 2*IDW+1)
- NREQ, 4, number of requesters (2..8); IDW_ID = $clog2(NREQ)
- LAT, 3, multiplier latency: cycles from operands driven to i_mul_res valid
- DEPTH, 8, response FIFO entries = issue credits (≥1; ≥LAT+2 for full throughput)
- i_clk  in  1  clock
- i_rstn  in  1  reset; one clock, reset asynchronous and active-low
- i_req_vld  in  NREQ  per-requester request valid
- o_req_rdy  out  NREQ  per-requester accept (one-hot or zero)
- i_req_a  in  NREQ*IDW  packed operand A, requester i at [i*IDW +: IDW]
- i_req_b  in  NREQ*IDW  packed operand B
- i_req_carry  in  NREQ  carry-in per requester
- o_mul_a / o_mul_b  out  IDW  registered multiplier operands
- o_mul_carry  out  1  registered multiplier carry-in
- i_mul_res  in  ODW  multiplier result
- o_rsp_vld  out  1  response valid
- i_rsp_rdy  in  1  response accept
- o_rsp_id  out  IDW_ID  requester id of head response
- o_rsp_res  out  ODW  head result

## Operation
- Credit count cnt = in-flight + FIFO occupancy, 0..DEPTH. Issue allowed iff cnt < DEPTH. No same-cycle pop bypass.
- Arbitration: round-robin pointer ptr (last granted). Search starts at ptr+1 mod NREQ. The first requester with i_req_vld set wins if issue is allowed.
- o_req_rdy[winner] = 1 combinationally; all other bits 0. o_req_rdy is 0 for every requester when no credit is available. Handshake = vld & rdy. ptr updates to winner on handshake only.
- On handshake: o_mul_a/b/carry load the winner's operands. With no handshake they hold their previous value.
- Tag pipeline: LAT+1 stages of {vld, id}. Stage 0 loads on the issue edge. At the final stage, vld=1 writes {id, i_mul_res} into the FIFO.
- FIFO: o_rsp_vld = !empty. o_rsp_id and o_rsp_res show the head. Pop on o_rsp_vld & i_rsp_rdy.
- cnt +1 on issue, −1 on pop; unchanged when both occur. FIFO never overflows by construction. Overflow is an assertion failure.
- A requester must hold vld and operands stable until accepted. The arbiter does not depend on this for correctness.

## Timing
- Reset values: o_req_rdy=0, o_mul_a/b/carry=0, o_rsp_vld=0, o_rsp_id=0, o_rsp_res=0, ptr=NREQ-1 (requester 0 wins first), cnt=0, tag pipeline cleared, FIFO empty.
- Handshake at edge k → o_mul_* valid after edge k → i_mul_res valid LAT cycles later → FIFO write at edge k+LAT+1 → o_rsp_vld high after edge k+LAT+1. Minimum latency LAT+1 = 4 cycles.
- Throughput: 1 issue/cycle while i_rsp_rdy=1 and DEPTH ≥ LAT+2.
- Responses are returned strictly in issue order.
- Reset mid-operation discards all in-flight and buffered results. No response is produced for them.

## Configuration
- MMM_NLP_ARB_STAT_EN defined: adds outputs o_stat_issue (32b, count of issues) and o_stat_stall (32b, cycles with any i_req_vld set but cnt==DEPTH). Both are wrap-around counters and reset to 0.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package mmm_nlp_pkg: IDW/ODW/LAT default constants, id-width function, response record type {id, res}.
- Sub-module mmm_nlp_rsp_fifo: synchronous FIFO, DEPTH entries, registered pointers, empty/full/count outputs.
- Round-robin logic, credit counter and tag pipeline stay in the top module.

## Test plan
- Single request: requester 2 sends a=3, b=5, carry=1 → o_rsp_vld after 4 cycles, id=2, res=16.
- All four requesters hold vld with random operands for 8 cycles, i_rsp_rdy=1 → grants in order 0,1,2,3,0,1,2,3. Every result equals a*b+carry.
- Max operands a=b=2^90−1, carry=1 → res=(2^90−1)^2+1 with no truncation in 181 bits.
- i_rsp_rdy=0 with continuous requests → exactly 8 handshakes, then o_req_rdy=0. Raising i_rsp_rdy resumes issue one cycle after the first pop.
- Assert reset with 3 in flight and 2 buffered → o_rsp_vld=0. No stale responses after reset release. First grant goes to requester 0.
- With MMM_NLP_ARB_STAT_EN: run the backpressure scenario for 20 cycles → o_stat_issue=8, o_stat_stall=12.

Source files
------------

// File: rtl/mmm_nlp_pkg.sv
// Shared constants and record types for the NLP multiplier arbiter slice.
package mmm_nlp_pkg;

  localparam int unsigned MMM_IDW  = 90;
  localparam int unsigned MMM_ODW  = 181;
  localparam int unsigned MMM_LAT  = 3;
  localparam int unsigned MMM_NREQ = 4;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned MMM_IDW_ID = id_width(MMM_NREQ);

  typedef struct packed {
    logic [MMM_IDW_ID-1:0] id;
    logic [MMM_ODW-1:0]    res;
  } rsp_t;

endpackage

// File: rtl/mmm_nlp_rsp_fifo.sv
// Response FIFO: DEPTH entries of type T, registered pointers, empty/full/count status.
module mmm_nlp_rsp_fifo
  import mmm_nlp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = rsp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_i,
  input  T                           wdata_i,
  input  logic                       rd_i,
  output T                           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign do_wr   = wr_i && !full_o;
  assign do_rd   = rd_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_wr) wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
    if (do_rd) rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
    if (do_wr && !do_rd)      cnt_d = cnt_q + CW'(1);
    else if (!do_wr && do_rd) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q] <= wdata_i;
  end

  // Head reads as zero while empty so the response outputs are clean after reset.
  always_comb begin
    rdata_o = '0;
    if (!empty_o) rdata_o = mem_q[rptr_q];
  end

  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(wr_i && full_o));

endmodule

// File: rtl/mmm_nlp_mul_arb.sv
// Round-robin issue arbiter for the shared 90-bit multiplier with credit-protected response FIFO.
// Optional statistics counters are enabled by defining MMM_NLP_ARB_STAT_EN.
module mmm_nlp_mul_arb
  import mmm_nlp_pkg::*;
#(
  parameter int unsigned IDW   = MMM_IDW,
  parameter int unsigned ODW   = MMM_ODW,
  parameter int unsigned NREQ  = MMM_NREQ,
  parameter int unsigned LAT   = MMM_LAT,
  parameter int unsigned DEPTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic [NREQ-1:0]             i_req_vld,
  output logic [NREQ-1:0]             o_req_rdy,
  input  logic [NREQ*IDW-1:0]         i_req_a,
  input  logic [NREQ*IDW-1:0]         i_req_b,
  input  logic [NREQ-1:0]             i_req_carry,
  output logic [IDW-1:0]              o_mul_a,
  output logic [IDW-1:0]              o_mul_b,
  output logic                        o_mul_carry,
  input  logic [ODW-1:0]              i_mul_res,
  output logic                        o_rsp_vld,
  input  logic                        i_rsp_rdy,
  output logic [id_width(NREQ)-1:0]   o_rsp_id,
  output logic [ODW-1:0]              o_rsp_res
`ifdef MMM_NLP_ARB_STAT_EN
  ,
  output logic [31:0]                 o_stat_issue,
  output logic [31:0]                 o_stat_stall
`endif
);

  localparam int unsigned IDW_ID = id_width(NREQ);
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              vld;
    logic [IDW_ID-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [IDW_ID-1:0] id;
    logic [ODW-1:0]    res;
  } rec_t;

  logic [IDW-1:0]    req_a [NREQ];
  logic [IDW-1:0]    req_b [NREQ];
  logic [IDW_ID-1:0] ptr_q, ptr_d, win, cand;
  logic [CW-1:0]     cnt_q, cnt_d, fifo_cnt;
  logic              credit_ok, can_issue, found, hs, pop;
  logic              fifo_empty, fifo_full;
  tag_t              tag_q [LAT+1];
  rec_t              wr_rec, rd_rec;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_a[g] = i_req_a[g*IDW +: IDW];
    assign req_b[g] = i_req_b[g*IDW +: IDW];
  end

  assign credit_ok = (cnt_q < CW'(DEPTH));
  assign can_issue = i_rstn && credit_ok;

  // Search begins one past the last grant, so the previous winner has lowest priority.
  always_comb begin
    found     = 1'b0;
    win       = ptr_q;
    cand      = '0;
    o_req_rdy = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW_ID'((32'(ptr_q) + k) % NREQ);
      if (!found && i_req_vld[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    hs = found && can_issue;
    if (hs) o_req_rdy[win] = 1'b1;
  end

  assign pop = o_rsp_vld && i_rsp_rdy;

  always_comb begin
    ptr_d = hs ? win : ptr_q;
    cnt_d = cnt_q;
    if (hs && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!hs && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr_q       <= IDW_ID'(NREQ - 1);
      cnt_q       <= '0;
      o_mul_a     <= '0;
      o_mul_b     <= '0;
      o_mul_carry <= 1'b0;
      for (int unsigned s = 0; s <= LAT; s++) tag_q[s] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (hs) begin
        o_mul_a     <= req_a[win];
        o_mul_b     <= req_b[win];
        o_mul_carry <= i_req_carry[win];
      end
      tag_q[0] <= '{vld: hs, id: win};
      for (int unsigned s = 1; s <= LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign wr_rec = '{id: tag_q[LAT].id, res: i_mul_res};

  mmm_nlp_rsp_fifo #(
    .DEPTH (DEPTH),
    .T     (rec_t)
  ) u_rsp_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rstn),
    .wr_i    (tag_q[LAT].vld),
    .wdata_i (wr_rec),
    .rd_i    (pop),
    .rdata_o (rd_rec),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  assign o_rsp_vld = !fifo_empty;
  assign o_rsp_id  = rd_rec.id;
  assign o_rsp_res = rd_rec.res;

  credit_cover_a: assert property (@(posedge i_clk) disable iff (!i_rstn) fifo_cnt <= cnt_q);
  credit_full_a:  assert property (@(posedge i_clk) disable iff (!i_rstn)
                                   fifo_full |-> (cnt_q == CW'(DEPTH)));

`ifdef MMM_NLP_ARB_STAT_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_stat_issue <= '0;
      o_stat_stall <= '0;
    end else begin
      o_stat_issue <= o_stat_issue + 32'(hs);
      o_stat_stall <= o_stat_stall + 32'((|i_req_vld) && !credit_ok);
    end
  end
`endif

endmodule

// File: tb/tb_mmm_nlp_mul_arb.sv
// Directed bench for mmm_nlp_mul_arb with round-robin/credit model and in-order response scoreboard.
module tb_mmm_nlp_mul_arb;

  localparam int unsigned IDW    = 90;
  localparam int unsigned ODW    = 181;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned LAT    = 3;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned IDW_ID = 2;

  logic                 i_clk = 1'b0;
  logic                 i_rstn = 1'b1;
  logic [NREQ-1:0]      i_req_vld = '0;
  logic [NREQ-1:0]      o_req_rdy;
  logic [NREQ*IDW-1:0]  i_req_a = '0;
  logic [NREQ*IDW-1:0]  i_req_b = '0;
  logic [NREQ-1:0]      i_req_carry = '0;
  logic [IDW-1:0]       o_mul_a, o_mul_b;
  logic                 o_mul_carry;
  logic [ODW-1:0]       i_mul_res;
  logic                 o_rsp_vld;
  logic                 i_rsp_rdy = 1'b1;
  logic [IDW_ID-1:0]    o_rsp_id;
  logic [ODW-1:0]       o_rsp_res;
`ifdef MMM_NLP_ARB_STAT_EN
  logic [31:0]          o_stat_issue, o_stat_stall;
`endif

  always #5 i_clk = ~i_clk;

  mmm_nlp_mul_arb #(
    .IDW   (IDW),
    .ODW   (ODW),
    .NREQ  (NREQ),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_req_vld   (i_req_vld),
    .o_req_rdy   (o_req_rdy),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .i_req_carry (i_req_carry),
    .o_mul_a     (o_mul_a),
    .o_mul_b     (o_mul_b),
    .o_mul_carry (o_mul_carry),
    .i_mul_res   (i_mul_res),
    .o_rsp_vld   (o_rsp_vld),
    .i_rsp_rdy   (i_rsp_rdy),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_res   (o_rsp_res)
`ifdef MMM_NLP_ARB_STAT_EN
    ,
    .o_stat_issue (o_stat_issue),
    .o_stat_stall (o_stat_stall)
`endif
  );

  function automatic logic [ODW-1:0] mulc(input logic [IDW-1:0] a, input logic [IDW-1:0] b,
                                           input logic c);
    logic [ODW-1:0] r;
    r = ODW'(a) * ODW'(b) + ODW'(c);
    return r;
  endfunction

  function automatic logic [IDW-1:0] rnd();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[IDW-1:0];
  endfunction

  // Pipelined multiplier: result of the registered operands appears LAT cycles later.
  logic [ODW-1:0] mpipe [LAT];
  always @(posedge i_clk) begin
    mpipe[0] <= mulc(o_mul_a, o_mul_b, o_mul_carry);
    for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
  end
  assign i_mul_res = mpipe[LAT-1];

  typedef struct {
    logic [IDW_ID-1:0] id;
    logic [ODW-1:0]    res;
    int unsigned       due;
  } exp_t;

  int                checks = 0;
  int                failures = 0;
  exp_t              sbq[$];
  int unsigned       grants[$];
  logic [IDW_ID-1:0] m_ptr;
  int unsigned       m_cnt, ncyc, obs_hs, h0;
  logic [IDW-1:0]    m_a, m_b;
  logic              m_c;
  bit                reroll;
  logic [IDW-1:0]    ra [NREQ];
  logic [IDW-1:0]    rb [NREQ];
  logic              rc [NREQ];
  logic [ODW-1:0]    emax;

  task automatic step();
    bit                found, evld, pop;
    logic [IDW_ID-1:0] idx, w;
    logic [NREQ-1:0]   erdy;
    i_req_a     = {ra[3], ra[2], ra[1], ra[0]};
    i_req_b     = {rb[3], rb[2], rb[1], rb[0]};
    i_req_carry = {rc[3], rc[2], rc[1], rc[0]};
    #1;
    found = 1'b0;
    w     = '0;
    erdy  = '0;
    if (m_cnt < DEPTH) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = IDW_ID'((32'(m_ptr) + k) % NREQ);
        if (!found && i_req_vld[idx]) begin
          found = 1'b1;
          w     = idx;
        end
      end
    end
    if (found) erdy[w] = 1'b1;
    checks++;
    if (o_req_rdy !== erdy) begin
      failures++;
      $error("FAIL req_rdy: observed=%0h expected=%0h", o_req_rdy, erdy);
    end
    checks++;
    if (o_mul_a !== m_a) begin
      failures++;
      $error("FAIL mul_a: observed=%0h expected=%0h", o_mul_a, m_a);
    end
    checks++;
    if (o_mul_b !== m_b) begin
      failures++;
      $error("FAIL mul_b: observed=%0h expected=%0h", o_mul_b, m_b);
    end
    checks++;
    if (o_mul_carry !== m_c) begin
      failures++;
      $error("FAIL mul_carry: observed=%0h expected=%0h", o_mul_carry, m_c);
    end
    evld = (sbq.size() > 0) && (sbq[0].due <= ncyc);
    checks++;
    if (o_rsp_vld !== evld) begin
      failures++;
      $error("FAIL rsp_vld: observed=%0h expected=%0h", o_rsp_vld, evld);
    end
    if (evld) begin
      checks++;
      if (o_rsp_id !== sbq[0].id) begin
        failures++;
        $error("FAIL rsp_id: observed=%0h expected=%0h", o_rsp_id, sbq[0].id);
      end
      checks++;
      if (o_rsp_res !== sbq[0].res) begin
        failures++;
        $error("FAIL rsp_res: observed=%0h expected=%0h", o_rsp_res, sbq[0].res);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (o_req_rdy[IDW_ID'(i)] && i_req_vld[IDW_ID'(i)]) begin
        obs_hs++;
        grants.push_back(i);
      end
    end
    pop = evld && i_rsp_rdy;
    if (pop) sbq.delete(0);
    if (found) begin
      m_ptr = w;
      m_a   = ra[w];
      m_b   = rb[w];
      m_c   = rc[w];
      sbq.push_back('{id: w, res: mulc(ra[w], rb[w], rc[w]), due: ncyc + LAT + 2});
      if (reroll) begin
        ra[w] = rnd();
        rb[w] = rnd();
        rc[w] = 1'($urandom());
      end
    end
    if (found && !pop)      m_cnt++;
    else if (!found && pop) m_cnt--;
    @(negedge i_clk);
    ncyc++;
  endtask

  task automatic do_reset();
    i_req_vld = '1;
    i_rstn    = 1'b0;
    #1;
    checks++;
    if (o_req_rdy !== NREQ'(0)) begin
      failures++;
      $error("FAIL rst_req_rdy: observed=%0h expected=0", o_req_rdy);
    end
    checks++;
    if (o_rsp_vld !== 1'b0) begin
      failures++;
      $error("FAIL rst_rsp_vld: observed=%0h expected=0", o_rsp_vld);
    end
    checks++;
    if (o_rsp_id !== IDW_ID'(0)) begin
      failures++;
      $error("FAIL rst_rsp_id: observed=%0h expected=0", o_rsp_id);
    end
    checks++;
    if (o_rsp_res !== ODW'(0)) begin
      failures++;
      $error("FAIL rst_rsp_res: observed=%0h expected=0", o_rsp_res);
    end
    checks++;
    if (o_mul_a !== IDW'(0)) begin
      failures++;
      $error("FAIL rst_mul_a: observed=%0h expected=0", o_mul_a);
    end
    checks++;
    if (o_mul_b !== IDW'(0)) begin
      failures++;
      $error("FAIL rst_mul_b: observed=%0h expected=0", o_mul_b);
    end
    checks++;
    if (o_mul_carry !== 1'b0) begin
      failures++;
      $error("FAIL rst_mul_carry: observed=%0h expected=0", o_mul_carry);
    end
`ifdef MMM_NLP_ARB_STAT_EN
    checks++;
    if (o_stat_issue !== 32'd0) begin
      failures++;
      $error("FAIL rst_stat_issue: observed=%0h expected=0", o_stat_issue);
    end
    checks++;
    if (o_stat_stall !== 32'd0) begin
      failures++;
      $error("FAIL rst_stat_stall: observed=%0h expected=0", o_stat_stall);
    end
`endif
    m_ptr = IDW_ID'(NREQ - 1);
    m_cnt = 0;
    sbq.delete();
    m_a = '0;
    m_b = '0;
    m_c = 1'b0;
    i_req_vld = '0;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = '0;
      rb[i] = '0;
      rc[i] = 1'b0;
    end
    ncyc   = 0;
    obs_hs = 0;
    reroll = 0;
    #2;
    do_reset();

    // Single request from requester 2: 3*5+1 = 16 after 4 cycles.
    ra[2] = 90'd3;
    rb[2] = 90'd5;
    rc[2] = 1'b1;
    i_req_vld = 4'b0100;
    step();
    i_req_vld = '0;
    repeat (4) step();
    #1;
    checks++;
    if (o_rsp_vld !== 1'b1) begin
      failures++;
      $error("FAIL single_vld: observed=%0h expected=1", o_rsp_vld);
    end
    checks++;
    if (o_rsp_id !== 2'd2) begin
      failures++;
      $error("FAIL single_id: observed=%0h expected=2", o_rsp_id);
    end
    checks++;
    if (o_rsp_res !== ODW'(16)) begin
      failures++;
      $error("FAIL single_res: observed=%0h expected=10", o_rsp_res);
    end
    repeat (4) step();

    // All four requesters continuously valid: grants 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = rnd();
      rb[i] = rnd();
      rc[i] = 1'($urandom());
    end
    reroll = 1;
    grants.delete();
    i_req_vld = '1;
    repeat (8) step();
    i_req_vld = '0;
    reroll = 0;
    checks++;
    if (grants.size() !== 8) begin
      failures++;
      $error("FAIL rr_count: observed=%0d expected=8", grants.size());
    end
    for (int i = 0; i < 8 && i < grants.size(); i++) begin
      checks++;
      if (grants[i] !== 32'(i % 4)) begin
        failures++;
        $error("FAIL rr_order: observed=%0d expected=%0d", grants[i], i % 4);
      end
    end
    repeat (8) step();

    // Maximum operands, no truncation: (2^90-1)^2+1.
    emax = '0;
    emax[179:91] = '1;
    emax[1] = 1'b1;
    ra[1] = '1;
    rb[1] = '1;
    rc[1] = 1'b1;
    i_req_vld = 4'b0010;
    step();
    i_req_vld = '0;
    repeat (4) step();
    #1;
    checks++;
    if (o_rsp_vld !== 1'b1) begin
      failures++;
      $error("FAIL max_vld: observed=%0h expected=1", o_rsp_vld);
    end
    checks++;
    if (o_rsp_id !== 2'd1) begin
      failures++;
      $error("FAIL max_id: observed=%0h expected=1", o_rsp_id);
    end
    checks++;
    if (o_rsp_res !== emax) begin
      failures++;
      $error("FAIL max_res: observed=%0h expected=%0h", o_rsp_res, emax);
    end
    repeat (4) step();

    // Backpressure: exactly DEPTH handshakes, then stall until the first pop.
    do_reset();
    i_rsp_rdy = 1'b0;
    reroll = 1;
    i_req_vld = '1;
    h0 = obs_hs;
    repeat (20) step();
    #1;
    checks++;
    if ((obs_hs - h0) !== 32'd8) begin
      failures++;
      $error("FAIL bp_handshakes: observed=%0d expected=8", obs_hs - h0);
    end
    checks++;
    if (o_req_rdy !== NREQ'(0)) begin
      failures++;
      $error("FAIL bp_req_rdy: observed=%0h expected=0", o_req_rdy);
    end
`ifdef MMM_NLP_ARB_STAT_EN
    checks++;
    if (o_stat_issue !== 32'd8) begin
      failures++;
      $error("FAIL stat_issue: observed=%0d expected=8", o_stat_issue);
    end
    checks++;
    if (o_stat_stall !== 32'd12) begin
      failures++;
      $error("FAIL stat_stall: observed=%0d expected=12", o_stat_stall);
    end
`endif
    i_rsp_rdy = 1'b1;
    repeat (12) step();
    i_req_vld = '0;
    reroll = 0;
    repeat (12) step();

    // Reset with 3 in flight and 2 buffered discards all of them.
    do_reset();
    i_rsp_rdy = 1'b0;
    reroll = 1;
    i_req_vld = '1;
    repeat (5) step();
    i_req_vld = '0;
    reroll = 0;
    step();
    #1;
    checks++;
    if (o_rsp_vld !== 1'b1) begin
      failures++;
      $error("FAIL pre_rst_vld: observed=%0h expected=1", o_rsp_vld);
    end
    do_reset();
    i_rsp_rdy = 1'b1;
    repeat (10) step();
    i_req_vld = 4'b1001;
    #1;
    checks++;
    if (o_req_rdy !== 4'b0001) begin
      failures++;
      $error("FAIL post_rst_first_grant: observed=%0h expected=1", o_req_rdy);
    end
    step();
    i_req_vld = '0;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
